// File: rtl/text_console.sv
// Byte-stream terminal front end for the character buffer: cursor tracking, printable writes, CR/LF/BS/FF, line/screen clears.
// Optional feature: define TEXTCON_LF_CR_EN so that LF also returns the cursor to column 0.
module text_console #(
    parameter int unsigned COLS_LOG2      = 6,
    parameter int unsigned ROWS_LOG2      = 5,
    parameter logic [7:0]  FILL_CHAR      = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [7:0]                     i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [ROWS_LOG2+COLS_LOG2-1:0] o_addr,
    output logic [7:0]                     o_data,
    output logic                           o_we,
    output logic [ROWS_LOG2+COLS_LOG2-1:0] o_cursor,
    output logic                           o_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_LINE = 2'd1,
        CLR_SCR  = 2'd2
    } state_t;

    state_t                          state;
    logic [ROWS_LOG2-1:0]            row;
    logic [COLS_LOG2-1:0]            col;
    logic [ROWS_LOG2-1:0]            clr_row;
    logic [COLS_LOG2-1:0]            line_cnt;
    logic [ROWS_LOG2+COLS_LOG2-1:0]  scr_cnt;
    logic                            is_ctrl;

    assign is_ctrl  = (i_data < 8'h20) || (i_data == 8'h7F);
    assign o_cursor = {row, col};
    assign o_busy   = ~o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= CLEAR_ON_RESET ? CLR_SCR : IDLE;
            o_ready  <= !CLEAR_ON_RESET;
            row      <= '0;
            col      <= '0;
            clr_row  <= '0;
            line_cnt <= '0;
            scr_cnt  <= '0;
            o_we     <= 1'b0;
            o_addr   <= '0;
            o_data   <= FILL_CHAR;
        end else begin
            o_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (!is_ctrl) begin
                            o_we   <= 1'b1;
                            o_addr <= {row, col};
                            o_data <= i_data;
                            // Printing into the last column wraps and blanks the new row.
                            if (col == '1) begin
                                col      <= '0;
                                row      <= row + 1'b1;
                                clr_row  <= row + 1'b1;
                                line_cnt <= '0;
                                state    <= CLR_LINE;
                                o_ready  <= 1'b0;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            case (i_data)
                                8'h0D: col <= '0;
                                8'h0A: begin
                                    row      <= row + 1'b1;
                                    clr_row  <= row + 1'b1;
`ifdef TEXTCON_LF_CR_EN
                                    col      <= '0;
`endif
                                    line_cnt <= '0;
                                    state    <= CLR_LINE;
                                    o_ready  <= 1'b0;
                                end
                                8'h08: begin
                                    if (col != '0) begin
                                        col    <= col - 1'b1;
                                        o_we   <= 1'b1;
                                        o_addr <= {row, col - 1'b1};
                                        o_data <= FILL_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    scr_cnt <= '0;
                                    state   <= CLR_SCR;
                                    o_ready <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_LINE: begin
                    o_we     <= 1'b1;
                    o_addr   <= {clr_row, line_cnt};
                    o_data   <= FILL_CHAR;
                    line_cnt <= line_cnt + 1'b1;
                    if (line_cnt == '1) begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end
                end
                CLR_SCR: begin
                    o_we    <= 1'b1;
                    o_addr  <= scr_cnt;
                    o_data  <= FILL_CHAR;
                    scr_cnt <= scr_cnt + 1'b1;
                    if (scr_cnt == '1) begin
                        row     <= '0;
                        col     <= '0;
                        state   <= IDLE;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console: clears, printing, wraps, control codes, reset abort.
module tb_text_console;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic        valid;

    logic        ready, we, busy;
    logic [10:0] addr, cursor;
    logic [7:0]  wdata;
    logic        d0_ready, d0_we, d0_busy;
    logic [10:0] d0_addr, d0_cursor;
    logic [7:0]  d0_wdata;
    logic [19:0] wr_obs;

    int checks = 0;
    int errors = 0;

    assign wr_obs = {we, addr, wdata};

    text_console #(.COLS_LOG2(6), .ROWS_LOG2(5), .FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_addr(addr), .o_data(wdata), .o_we(we),
        .o_cursor(cursor), .o_busy(busy)
    );

    text_console #(.COLS_LOG2(6), .ROWS_LOG2(5), .FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
        .o_ready(d0_ready), .o_addr(d0_addr), .o_data(d0_wdata), .o_we(d0_we),
        .o_cursor(d0_cursor), .o_busy(d0_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents b, waits (bounded) for acceptance; returns at the negedge of the cycle after the accept.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 5000) begin
            errors++;
            $display("FAIL send_timeout: ready got %b want 1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (wr_obs !== {1'b0, 11'h000, 8'h20}) begin errors++; $display("FAIL reset_wr: got %h want %h", wr_obs, {1'b0, 11'h000, 8'h20}); end
        checks++; if (cursor !== 11'h000) begin errors++; $display("FAIL reset_cursor: got %h want 000", cursor); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (d0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_noclr: got %b want 1", d0_ready); end
        checks++; if ({d0_we, d0_addr, d0_wdata} !== {1'b0, 11'h000, 8'h20}) begin errors++; $display("FAIL reset_wr_noclr: got %h want %h", {d0_we, d0_addr, d0_wdata}, {1'b0, 11'h000, 8'h20}); end
    endtask

    task automatic test_clear_screen;
        rst_n = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'(i), 8'h20}) begin errors++; $display("FAIL clr_scr_wr: got %h want %h", wr_obs, {1'b1, 11'(i), 8'h20}); end
            checks++; if (ready !== (i == 2047)) begin errors++; $display("FAIL clr_scr_ready[%0d]: got %b want %b", i, ready, i == 2047); end
            checks++; if (d0_we !== 1'b0) begin errors++; $display("FAIL noclr_we: got %b want 0", d0_we); end
        end
        checks++; if (cursor !== 11'h000) begin errors++; $display("FAIL clr_scr_cursor: got %h want 000", cursor); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_scr_busy: got %b want 0", busy); end
    endtask

    task automatic test_print;
        logic [7:0] ctl [3];
        send(8'h41);
        checks++; if (wr_obs !== {1'b1, 11'h000, 8'h41}) begin errors++; $display("FAIL print_A: got %h want %h", wr_obs, {1'b1, 11'h000, 8'h41}); end
        send(8'h42);
        checks++; if (wr_obs !== {1'b1, 11'h001, 8'h42}) begin errors++; $display("FAIL print_B: got %h want %h", wr_obs, {1'b1, 11'h001, 8'h42}); end
        checks++; if (cursor !== 11'h002) begin errors++; $display("FAIL print_cursor: got %h want 002", cursor); end
        send(8'h80);
        checks++; if (wr_obs !== {1'b1, 11'h002, 8'h80}) begin errors++; $display("FAIL print_80: got %h want %h", wr_obs, {1'b1, 11'h002, 8'h80}); end
        ctl[0] = 8'h01; ctl[1] = 8'h7F; ctl[2] = 8'h1B;
        for (int k = 0; k < 3; k++) begin
            send(ctl[k]);
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL ignore_we[%h]: got %b want 0", ctl[k], we); end
            checks++; if (cursor !== 11'h003) begin errors++; $display("FAIL ignore_cursor[%h]: got %h want 003", ctl[k], cursor); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ignore_ready[%h]: got %b want 1", ctl[k], ready); end
        end
    endtask

    task automatic test_col_wrap;
        for (int k = 3; k < 63; k++) begin
            send(8'h78);
            checks++; if (wr_obs !== {1'b1, 11'(k), 8'h78}) begin errors++; $display("FAIL fill_row0: got %h want %h", wr_obs, {1'b1, 11'(k), 8'h78}); end
        end
        checks++; if (cursor !== 11'h03F) begin errors++; $display("FAIL wrap_pre_cursor: got %h want 03f", cursor); end
        send(8'h5A);
        checks++; if (wr_obs !== {1'b1, 11'h03F, 8'h5A}) begin errors++; $display("FAIL wrap_Z: got %h want %h", wr_obs, {1'b1, 11'h03F, 8'h5A}); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wrap_ready_low: got %b want 0", ready); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'h040 + 11'(i), 8'h20}) begin errors++; $display("FAIL wrap_clr: got %h want %h", wr_obs, {1'b1, 11'h040 + 11'(i), 8'h20}); end
            checks++; if (ready !== (i == 63)) begin errors++; $display("FAIL wrap_clr_ready[%0d]: got %b want %b", i, ready, i == 63); end
        end
        checks++; if (cursor !== 11'h040) begin errors++; $display("FAIL wrap_cursor: got %h want 040", cursor); end
    endtask

    task automatic test_backspace;
        send(8'h08);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL bs_col0_we: got %b want 0", we); end
        checks++; if (cursor !== 11'h040) begin errors++; $display("FAIL bs_col0_cursor: got %h want 040", cursor); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bs_col0_ready: got %b want 1", ready); end
        for (int k = 0; k < 3; k++) begin
            send(8'h61 + 8'(k));
            checks++; if (wr_obs !== {1'b1, 11'h040 + 11'(k), 8'h61 + 8'(k)}) begin errors++; $display("FAIL bs_setup: got %h want %h", wr_obs, {1'b1, 11'h040 + 11'(k), 8'h61 + 8'(k)}); end
        end
        send(8'h08);
        checks++; if (wr_obs !== {1'b1, 11'h042, 8'h20}) begin errors++; $display("FAIL bs_wr: got %h want %h", wr_obs, {1'b1, 11'h042, 8'h20}); end
        checks++; if (cursor !== 11'h042) begin errors++; $display("FAIL bs_cursor: got %h want 042", cursor); end
    endtask

    task automatic test_cr;
        send(8'h0D);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL cr_we: got %b want 0", we); end
        checks++; if (cursor !== 11'h040) begin errors++; $display("FAIL cr_cursor: got %h want 040", cursor); end
    endtask

    task automatic test_lf_wrap;
        logic [4:0]  rr;
        logic [10:0] exp_cur;
        for (int r = 2; r < 32; r++) begin
            rr = r[4:0];
            send(8'h0A);
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL lf_we: got %b want 0", we); end
            checks++; if (cursor !== {rr, 6'd0}) begin errors++; $display("FAIL lf_cursor: got %h want %h", cursor, {rr, 6'd0}); end
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                checks++; if (wr_obs !== {1'b1, rr, 6'(i), 8'h20}) begin errors++; $display("FAIL lf_clr: got %h want %h", wr_obs, {1'b1, rr, 6'(i), 8'h20}); end
            end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lf_clr_ready: got %b want 1", ready); end
        end
        for (int j = 0; j < 5; j++) begin
            send(8'h71);
            checks++; if (wr_obs !== {1'b1, 5'd31, 6'(j), 8'h71}) begin errors++; $display("FAIL last_row_wr: got %h want %h", wr_obs, {1'b1, 5'd31, 6'(j), 8'h71}); end
        end
        checks++; if (cursor !== 11'h7C5) begin errors++; $display("FAIL last_row_cursor: got %h want 7c5", cursor); end
`ifdef TEXTCON_LF_CR_EN
        exp_cur = 11'h000;
`else
        exp_cur = 11'h005;
`endif
        send(8'h0A);
        checks++; if (cursor !== exp_cur) begin errors++; $display("FAIL row_wrap_cursor: got %h want %h", cursor, exp_cur); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'(i), 8'h20}) begin errors++; $display("FAIL row_wrap_clr: got %h want %h", wr_obs, {1'b1, 11'(i), 8'h20}); end
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL row_wrap_ready: got %b want 1", ready); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] cur;
`ifdef TEXTCON_LF_CR_EN
        cur = 11'h000;
`else
        cur = 11'h005;
`endif
        data = 8'h6D; valid = 1'b1;
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, cur, 8'h6D}) begin errors++; $display("FAIL b2b_m: got %h want %h", wr_obs, {1'b1, cur, 8'h6D}); end
        data = 8'h6E;
        @(negedge clk);
        checks++; if (wr_obs !== {1'b1, cur + 11'd1, 8'h6E}) begin errors++; $display("FAIL b2b_n: got %h want %h", wr_obs, {1'b1, cur + 11'd1, 8'h6E}); end
        valid = 1'b0;
        @(negedge clk);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %b want 0", we); end
        cur = cur + 11'd2;
        while (cur[5:0] != 6'd63) begin
            send(8'h6B);
            checks++; if (wr_obs !== {1'b1, cur, 8'h6B}) begin errors++; $display("FAIL b2b_fill: got %h want %h", wr_obs, {1'b1, cur, 8'h6B}); end
            cur = cur + 11'd1;
        end
        send(8'h5A);
        checks++; if (wr_obs !== {1'b1, 11'h03F, 8'h5A}) begin errors++; $display("FAIL b2b_Z: got %h want %h", wr_obs, {1'b1, 11'h03F, 8'h5A}); end
        data = 8'h59; valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'h040 + 11'(i), 8'h20}) begin errors++; $display("FAIL b2b_clr: got %h want %h", wr_obs, {1'b1, 11'h040 + 11'(i), 8'h20}); end
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n65: got %b want 1", ready); end
        @(negedge clk);
        valid = 1'b0;
        checks++; if (wr_obs !== {1'b1, 11'h040, 8'h59}) begin errors++; $display("FAIL b2b_Y_n66: got %h want %h", wr_obs, {1'b1, 11'h040, 8'h59}); end
        checks++; if (cursor !== 11'h041) begin errors++; $display("FAIL b2b_cursor: got %h want 041", cursor); end
        @(negedge clk);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL b2b_Y_once: got %b want 0", we); end
    endtask

    task automatic test_form_feed;
        send(8'h0C);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL ff_we: got %b want 0", we); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ff_ready: got %b want 0", ready); end
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'(i), 8'h20}) begin errors++; $display("FAIL ff_clr: got %h want %h", wr_obs, {1'b1, 11'(i), 8'h20}); end
            checks++; if (ready !== (i == 2047)) begin errors++; $display("FAIL ff_ready[%0d]: got %b want %b", i, ready, i == 2047); end
        end
        checks++; if (cursor !== 11'h000) begin errors++; $display("FAIL ff_cursor: got %h want 000", cursor); end
    endtask

    task automatic test_reset_abort;
        send(8'h0C);
        repeat (101) @(negedge clk);
        checks++; if (wr_obs !== {1'b1, 11'd100, 8'h20}) begin errors++; $display("FAIL abort_at100: got %h want %h", wr_obs, {1'b1, 11'd100, 8'h20}); end
        rst_n = 1'b0;
        #1;
        checks++; if (wr_obs !== {1'b0, 11'h000, 8'h20}) begin errors++; $display("FAIL abort_wr: got %h want %h", wr_obs, {1'b0, 11'h000, 8'h20}); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wr_obs !== {1'b1, 11'(i), 8'h20}) begin errors++; $display("FAIL abort_restart: got %h want %h", wr_obs, {1'b1, 11'(i), 8'h20}); end
            checks++; if (d0_ready !== 1'b1) begin errors++; $display("FAIL abort_noclr_ready: got %b want 1", d0_ready); end
            checks++; if (d0_we !== 1'b0) begin errors++; $display("FAIL abort_noclr_we: got %b want 0", d0_we); end
            checks++; if (d0_cursor !== 11'h000) begin errors++; $display("FAIL abort_noclr_cursor: got %h want 000", d0_cursor); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        @(negedge clk);
        test_reset;
        test_clear_screen;
        test_print;
        test_col_wrap;
        test_backspace;
        test_cr;
        test_lf_wrap;
        test_back_to_back;
        test_form_feed;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
